// File: rtl/fan_light_sequencer.sv
// fan_light_sequencer: drives the fan-level bar LEDs and the timer indicator LED.
//   The fan bar ramps one LED per animation tick toward the selected level.
//   The timer LED is steady while running, blinks in the warning window and
//   flashes a fixed-length alert when the timer expires.
// Optional feature macro: LIGHT_DIM_EN (adds i_dim, 25% duty PWM dimming of the LEDs).
// Ports:
//   i_clk           system clock
//   i_reset         synchronous active-high reset
//   i_fan_on        fan enabled
//   i_level         selected fan level, 0..NUM_LEVELS valid
//   i_timer_on      timer running
//   i_timer_remain  timer remaining count (seconds)
//   i_dim           (LIGHT_DIM_EN only) dim the LEDs to 25% duty
//   o_fanlight      thermometer bar, bit0 = level 1
//   o_timerlight    timer indicator LED
//   o_alert         high while the expiry alert sequence runs
module fan_light_sequencer #(
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned LVL_W        = 4,
  parameter int unsigned REM_W        = 8,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLINK_TICKS  = 250,
  parameter int unsigned DONE_FLASHES = 3,
  parameter int unsigned WARN_LEVEL   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fan_on,
  input  logic [LVL_W-1:0]      i_level,
  input  logic                  i_timer_on,
  input  logic [REM_W-1:0]      i_timer_remain,
`ifdef LIGHT_DIM_EN
  input  logic                  i_dim,
`endif
  output logic [NUM_LEVELS-1:0] o_fanlight,
  output logic                  o_timerlight,
  output logic                  o_alert
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_LEVELS + 1);
  localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned FLS_W = $clog2(2 * DONE_FLASHES + 1);

  // Animation tick prescaler, free-running from reset.
  logic [PRE_W-1:0] pre_q;
  logic             tick_c;

  assign tick_c = (pre_q == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || tick_c) pre_q <= '0;
    else                   pre_q <= pre_q + PRE_W'(1);
  end

  // Fan target: out-of-range levels or fan off collapse to 0.
  logic [CNT_W-1:0] target_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next_c;
  logic             level_ok_c;

  always_comb begin
    level_ok_c = (i_level != '0) && (32'(i_level) <= NUM_LEVELS);
    target_c   = '0;
    if (i_fan_on && level_ok_c) target_c = CNT_W'(i_level);
  end

  // One step per tick toward the target; a new target redirects from the current count.
  always_comb begin
    cnt_next_c = cnt_q;
    if (tick_c) begin
      if (cnt_q < target_c)      cnt_next_c = cnt_q + CNT_W'(1);
      else if (cnt_q > target_c) cnt_next_c = cnt_q - CNT_W'(1);
    end
  end

  function automatic logic [NUM_LEVELS-1:0] thermo(input logic [CNT_W-1:0] c);
    logic [NUM_LEVELS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) t[i] = (32'(c) > i);
    return t;
  endfunction

  logic [NUM_LEVELS-1:0] bar_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      bar_q <= '0;
    end else begin
      cnt_q <= cnt_next_c;
      bar_q <= thermo(cnt_next_c);
    end
  end

  // Timer indicator FSM with registered light/alert.
  typedef enum logic [1:0] {T_OFF, T_ON, T_WARN, T_DONE} t_state_e;

  t_state_e         t_state_q;
  logic             phase_q;
  logic [BLK_W-1:0] blink_q;
  logic [FLS_W-1:0] flash_q;
  logic             light_q;
  logic             alert_q;
  logic             rem_zero_c;
  logic             rem_warn_c;

  assign rem_zero_c = (i_timer_remain == '0);
  assign rem_warn_c = (i_timer_remain <= REM_W'(WARN_LEVEL));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      t_state_q <= T_OFF;
      phase_q   <= 1'b0;
      blink_q   <= '0;
      flash_q   <= '0;
      light_q   <= 1'b0;
      alert_q   <= 1'b0;
    end else begin
      case (t_state_q)
        T_OFF: begin
          if (i_timer_on && !rem_zero_c) begin
            light_q <= 1'b1;
            if (rem_warn_c) begin
              t_state_q <= T_WARN;
              phase_q   <= 1'b1;
              blink_q   <= '0;
            end else begin
              t_state_q <= T_ON;
            end
          end
        end
        // Shared exit priority: timer off, then expiry, then warn/on window.
        T_ON, T_WARN: begin
          if (!i_timer_on) begin
            t_state_q <= T_OFF;
            light_q   <= 1'b0;
          end else if (rem_zero_c) begin
            t_state_q <= T_DONE;
            phase_q   <= 1'b1;
            flash_q   <= '0;
            light_q   <= 1'b1;
            alert_q   <= 1'b1;
          end else if (!rem_warn_c) begin
            t_state_q <= T_ON;
            light_q   <= 1'b1;
          end else if (t_state_q == T_ON) begin
            t_state_q <= T_WARN;
            phase_q   <= 1'b1;
            blink_q   <= '0;
            light_q   <= 1'b1;
          end else if (tick_c) begin
            if (blink_q == BLK_W'(BLINK_TICKS - 1)) begin
              phase_q <= !phase_q;
              light_q <= !phase_q;
              blink_q <= '0;
            end else begin
              blink_q <= blink_q + BLK_W'(1);
            end
          end
        end
        // Alert runs to completion regardless of timer inputs.
        T_DONE: begin
          if (tick_c) begin
            if (flash_q == FLS_W'(2 * DONE_FLASHES - 1)) begin
              t_state_q <= T_OFF;
              phase_q   <= 1'b0;
              flash_q   <= '0;
              light_q   <= 1'b0;
              alert_q   <= 1'b0;
            end else begin
              phase_q <= !phase_q;
              light_q <= !phase_q;
              flash_q <= flash_q + FLS_W'(1);
            end
          end
        end
        default: begin
          t_state_q <= T_OFF;
          light_q   <= 1'b0;
          alert_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef LIGHT_DIM_EN
  // Dimming gate is high on the cycle after the PWM counter wraps to 0.
  logic [1:0] pwm_q;
  logic       gate_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pwm_q  <= 2'd0;
      gate_q <= 1'b1;
    end else begin
      pwm_q  <= pwm_q + 2'd1;
      gate_q <= !i_dim || (pwm_q == 2'd3);
    end
  end

  assign o_fanlight   = bar_q & {NUM_LEVELS{gate_q}};
  assign o_timerlight = light_q & gate_q;
`else
  assign o_fanlight   = bar_q;
  assign o_timerlight = light_q;
`endif

  assign o_alert = alert_q;

endmodule

// File: tb/tb_fan_light_sequencer.sv
// tb_fan_light_sequencer: directed and randomized checks of fan_light_sequencer
// against a cycle-level behavioural model (tick index arithmetic, integer bar level).
module tb_fan_light_sequencer;

  localparam int unsigned NL = 3;
  localparam int unsigned LW = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned TD = 4;
  localparam int unsigned BT = 2;
  localparam int unsigned DF = 3;
  localparam int unsigned WL = 5;

  localparam int M_IDLE   = 0;
  localparam int M_STEADY = 1;
  localparam int M_BLINK  = 2;
  localparam int M_ALERT  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          fan_on;
  logic [LW-1:0] level;
  logic          timer_on;
  logic [RW-1:0] remain;
  logic          dim;
  logic [NL-1:0] fanlight;
  logic          timerlight;
  logic          alert;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int            m_cyc;
  int            m_cnt;
  int            m_mode;
  int            m_wt;
  int            m_dt;
  logic [NL-1:0] exp_fan;
  logic          exp_light;
  logic          exp_alert;

  always #5 clk = ~clk;

  fan_light_sequencer #(
    .NUM_LEVELS  (NL),
    .LVL_W       (LW),
    .REM_W       (RW),
    .TICK_DIV    (TD),
    .BLINK_TICKS (BT),
    .DONE_FLASHES(DF),
    .WARN_LEVEL  (WL)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_fan_on       (fan_on),
    .i_level        (level),
    .i_timer_on     (timer_on),
    .i_timer_remain (remain),
`ifdef LIGHT_DIM_EN
    .i_dim          (dim),
`endif
    .o_fanlight     (fanlight),
    .o_timerlight   (timerlight),
    .o_alert        (alert)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    bit tick;
    int tgt;
    if (reset) begin
      m_cyc = 0; m_cnt = 0; m_mode = M_IDLE; m_wt = 0; m_dt = 0;
      exp_fan = '0; exp_light = 1'b0; exp_alert = 1'b0;
      return;
    end
    m_cyc++;
    tick = ((m_cyc % TD) == 0);
    tgt  = (fan_on && int'(level) >= 1 && int'(level) <= int'(NL)) ? int'(level) : 0;
    if (tick) begin
      if (m_cnt < tgt)      m_cnt++;
      else if (m_cnt > tgt) m_cnt--;
    end
    case (m_mode)
      M_IDLE: begin
        if (timer_on && int'(remain) > int'(WL)) m_mode = M_STEADY;
        else if (timer_on && remain != 0) begin m_mode = M_BLINK; m_wt = 0; end
      end
      M_STEADY, M_BLINK: begin
        if (!timer_on)                      m_mode = M_IDLE;
        else if (remain == 0)               begin m_mode = M_ALERT; m_dt = 0; end
        else if (int'(remain) > int'(WL))   m_mode = M_STEADY;
        else if (m_mode == M_STEADY)        begin m_mode = M_BLINK; m_wt = 0; end
        else if (tick)                      m_wt++;
      end
      default: begin
        if (tick) m_dt++;
        if (m_dt == 2 * int'(DF)) m_mode = M_IDLE;
      end
    endcase
    exp_fan   = NL'((1 << m_cnt) - 1);
    exp_alert = (m_mode == M_ALERT);
    case (m_mode)
      M_STEADY: exp_light = 1'b1;
      M_BLINK:  exp_light = ((m_wt / int'(BT)) % 2) == 0;
      M_ALERT:  exp_light = (m_dt % 2) == 0;
      default:  exp_light = 1'b0;
    endcase
`ifdef LIGHT_DIM_EN
    if (dim && (m_cyc % 4) != 0) begin
      exp_fan   = '0;
      exp_light = 1'b0;
    end
`endif
  endtask

  task automatic cycle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("fanlight", 32'(fanlight), 32'(exp_fan));
      check("timerlight", 32'(timerlight), 32'(exp_light));
      check("alert", 32'(alert), 32'(exp_alert));
    end
  endtask

  initial begin
    int n;
    int ones;
    // Reset with arbitrary inputs.
    reset    = 1'b1;
    fan_on   = 1'b1;
    level    = 4'd2;
    timer_on = 1'b1;
    remain   = 8'd0;
    dim      = 1'b0;
    cycle(3);
    check("reset_fan", 32'(fanlight), 32'd0);
    check("reset_alert", 32'(alert), 32'd0);
    reset = 1'b0; fan_on = 1'b0; timer_on = 1'b0; remain = 8'd20;
    cycle(2);
    check("hold_fan", 32'(fanlight), 32'd0);

    // Ramp up, ramp down to level 1.
    fan_on = 1'b1; level = 4'd3;
    cycle(4); check("ramp_001", 32'(fanlight), 32'b001);
    cycle(4); check("ramp_011", 32'(fanlight), 32'b011);
    cycle(4); check("ramp_111", 32'(fanlight), 32'b111);
    level = 4'd1;
    cycle(4); check("down_011", 32'(fanlight), 32'b011);
    cycle(4); check("down_001", 32'(fanlight), 32'b001);
    level = 4'd3;
    cycle(8); check("back_111", 32'(fanlight), 32'b111);
    // Invalid level ramps down; redirect mid-ramp.
    level = 4'd5;
    cycle(4); check("inv_011", 32'(fanlight), 32'b011);
    level = 4'd3;
    cycle(4); check("redir_111", 32'(fanlight), 32'b111);
    fan_on = 1'b0;
    cycle(4); check("off_011", 32'(fanlight), 32'b011);
    cycle(4); check("off_001", 32'(fanlight), 32'b001);
    cycle(4); check("off_000", 32'(fanlight), 32'b000);

    // Timer steady, warning blink, steady again, off.
    timer_on = 1'b1; remain = 8'd20;
    cycle(1); check("timer_on", 32'(timerlight), 32'd1);
    remain = 8'd5;
    cycle(1); check("warn_entry", 32'(timerlight), 32'd1);
    cycle(16);
    remain = 8'd6;
    cycle(1); check("warn_exit", 32'(timerlight), 32'd1);
    cycle(8);
    timer_on = 1'b0;
    cycle(1); check("timer_off", 32'(timerlight), 32'd0);

    // Expiry alert; dropping the timer does not shorten it.
    timer_on = 1'b1; remain = 8'd20;
    cycle(1);
    remain = 8'd0;
    cycle(1);
    check("alert_entry", 32'(alert), 32'd1);
    check("alert_light", 32'(timerlight), 32'd1);
    timer_on = 1'b0; remain = 8'd9;
    n = 1;
    while (alert === 1'b1 && n < 40) begin
      cycle(1);
      if (alert === 1'b1) n++;
    end
    check("alert_len_ok", 32'(n >= 21 && n <= 24), 32'd1);
    check("alert_done_light", 32'(timerlight), 32'd0);

    // Reset mid-alert and mid-ramp.
    fan_on = 1'b1; level = 4'd3; timer_on = 1'b1; remain = 8'd20;
    cycle(1);
    remain = 8'd0;
    cycle(5);
    reset = 1'b1;
    cycle(1);
    check("rst_mid_fan", 32'(fanlight), 32'd0);
    check("rst_mid_light", 32'(timerlight), 32'd0);
    check("rst_mid_alert", 32'(alert), 32'd0);
    reset = 1'b0; timer_on = 1'b0;

`ifdef LIGHT_DIM_EN
    cycle(16);
    dim  = 1'b1;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1);
      if (fanlight[0] === 1'b1) ones++;
    end
    check("dim_duty", 32'(ones), 32'd2);
    dim = 1'b0;
`else
    ones = 0;
`endif

    // Randomized phase.
    for (int it = 0; it < 3000; it++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) fan_on = ~fan_on;
      if ($urandom_range(0, 11) == 0) level = LW'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) timer_on = ~timer_on;
      if ($urandom_range(0, 7) == 0)
        remain = ($urandom_range(0, 1) == 0) ? RW'($urandom_range(0, 8)) : RW'($urandom_range(6, 40));
`ifdef LIGHT_DIM_EN
      if ($urandom_range(0, 31) == 0) dim = ~dim;
`endif
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
